hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 139 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Drives NUM_DIGITS seven-segment digits from a hex value. One decoder is
//   shared across all digits: after a load, digits are decoded one per cycle
//   into a shadow buffer. The shadow buffer is then copied to the display
//   register in a single edge, so a partially updated frame is never shown.
//   A free-running blink counter can blank the whole display.
//
// Ports
//   clk_i, rst_i   clock, async active-high reset
//   value_i        4*NUM_DIGITS hex value; nibble k drives digit k (0 = rightmost)
//   dots_i         per-digit decimal point request (1 = on)
//   blank_lz_i     blank leading zeros; captured with the load
//   load_valid_i   load request; load_ready_o accepts it
//   blink_en_i     live blink enable
//   hex_o          8 bits per digit: {dot, g..a}; all bits are low-active
//   busy_o         update in progress (~load_ready_o)
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dots_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic                    blank_lz_i,
  input  logic                    blink_en_i,
  output logic [8*NUM_DIGITS-1:0] hex_o,
  output logic                    busy_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_e;

  state_e                          state_q;
  logic [IW-1:0]                   idx_q;
  logic                            ready_q;
  logic [NUM_DIGITS-1:0][3:0]      val_q;
  logic [NUM_DIGITS-1:0]           dots_q;
  logic                            blank_q;
  logic [NUM_DIGITS-1:0][7:0]      shadow_q;
  logic [NUM_DIGITS-1:0][7:0]      disp_q;
  logic [CW-1:0]                   cnt_q;
  logic                            phase_q;

  logic [7:0]                      shadow_byte_d;
  logic                            upper_nz;
  logic [6:0]                      seg;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // The single shared decoder, steered by idx_q. A digit is a leading zero
  // when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(idx_q) && val_q[j] != 4'h0) upper_nz = 1'b1;
    seg = seg7(val_q[idx_q]);
    if (blank_q && idx_q != '0 && !upper_nz) seg = 7'h7F;
    shadow_byte_d = {~dots_q[idx_q], seg};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      val_q    <= '0;
      dots_q   <= '0;
      blank_q  <= 1'b0;
      shadow_q <= '1;
      disp_q   <= '1;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      // Blink timebase runs regardless of the update FSM.
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (load_valid_i && ready_q) begin
            val_q   <= value_i;
            dots_q  <= dots_i;
            blank_q <= blank_lz_i;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          shadow_q[idx_q] <= shadow_byte_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        COMMIT: begin
          disp_q  <= shadow_q;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready_o = ready_q;
  assign busy_o       = ~ready_q;
  // Blink mask is purely on the output path so updates continue underneath.
  assign hex_o        = (blink_en_i && !phase_q) ? '1 : disp_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;
  localparam int N = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] value;
  logic [N-1:0]  dots;
  logic          valid, ready, blank, blink;
  logic [8*N-1:0] hex;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [8*N-1:0] cur_disp;

  hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .value_i(value), .dots_i(dots),
    .load_valid_i(valid), .load_ready_o(ready), .blank_lz_i(blank),
    .blink_en_i(blink), .hex_o(hex), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one value, measure busy length, check hold and final frame.
  task automatic do_load(input logic [23:0] v, input logic [5:0] d, input logic b,
                         input logic [47:0] exp, input string nm);
    int n;
    int bad;
    value = v; dots = d; blank = b; valid = 1'b1;
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_wait got %b want 1", nm, ready); end
    tick();
    valid = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 20) begin
      if (hex !== cur_disp) bad++;
      tick(); n++;
    end
    checks++;
    if (n != 7) begin errors++; $display("FAIL %s_busy_len got %0d want 7", nm, n); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_hold_prev got %0d bad cycles want 0", nm, bad); end
    checks++;
    if (hex !== exp) begin errors++; $display("FAIL %s_value got %h want %h", nm, hex, exp); end
    cur_disp = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1; value = '0; dots = '0; valid = 1'b0; blank = 1'b0; blink = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (hex !== '1) begin errors++; $display("FAIL reset_hex got %h want all ff", hex); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    cur_disp = '1;
  endtask

  task automatic test_basic();
    do_load(24'h000123, 6'b0, 1'b0, 48'hC0C0C0F9A4B0, "basic");
  endtask

  task automatic test_blank_lz();
    do_load(24'h000123, 6'b0, 1'b1, 48'hFFFFFFF9A4B0, "blank_lz");
    do_load(24'h000000, 6'b100001, 1'b1, 48'h7FFFFFFFFF40, "zero_dots");
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    value = 24'hABCDEF; dots = '0; blank = 1'b0; valid = 1'b1;
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    tick();                          // first request accepted here
    value = 24'h111111;              // second request held while busy
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (ready !== 1'b0) bad++;
      if (hex !== cur_disp) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_first_busy got %0d bad samples want 0", bad); end
    checks++;
    if (hex !== 48'h8883C6A1868E) begin errors++; $display("FAIL b2b_first_value got %h want 8883c6a1868e", hex); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_again got %b want 1", ready); end
    tick();                          // second request accepted here
    valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy %b want 1", busy); end
    n = 0; bad = 0;
    while (busy && n < 20) begin
      if (hex !== 48'h8883C6A1868E) bad++;
      tick(); n++;
    end
    checks++;
    if (n != 7 || bad != 0) begin errors++; $display("FAIL b2b_second_busy got len %0d bad %0d want 7 0", n, bad); end
    checks++;
    if (hex !== 48'hF9F9F9F9F9F9) begin errors++; $display("FAIL b2b_second_value got %h want f9f9f9f9f9f9", hex); end
    cur_disp = 48'hF9F9F9F9F9F9;
  endtask

  task automatic test_blink();
    logic [47:0] disp, exp;
    int bad;
    blink = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;                      // counter starts at 0, phase visible
    value = 24'h000001; dots = '0; blank = 1'b0; valid = 1'b1;
    bad = 0;
    for (int n = 0; n < 24; n++) begin
      disp = (n >= 8) ? 48'hC0C0C0C0C0F9 : '1;
      exp  = (((n / 4) % 2) == 0) ? disp : '1;
      checks++;
      if (hex !== exp) begin errors++; $display("FAIL blink_n%0d got %h want %h", n, hex, exp); end
      tick();
      if (n == 0) valid = 1'b0;
    end
    blink = 1'b0;
    cur_disp = 48'hC0C0C0C0C0F9;
  endtask

  task automatic test_reset_mid();
    int bad;
    value = 24'h654321; dots = '0; blank = 1'b0; valid = 1'b1;
    tick();                          // accepted
    valid = 1'b0;
    tick(); tick();                  // third DECODE cycle
    rst = 1'b1;
    #1;
    checks++;
    if (hex !== '1) begin errors++; $display("FAIL rstmid_hex got %h want all ff", hex); end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b/%b want 1/0", ready, busy); end
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hex !== '1 || ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_stays_dark got %0d bad samples want 0", bad); end
    cur_disp = '1;
    do_load(24'h000007, 6'b0, 1'b0, 48'hC0C0C0C0C0F8, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank_lz();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
